// File: rtl/resolution_overlay_if.sv
// Pixel-stream, timing and ROM signals between the timing generator,
// the resolution ROM and the resolution_overlay block.
`ifndef RESLINE_SIZE
`define RESLINE_SIZE 16
`endif

interface resolution_overlay_if #(
   parameter int LINE_W = `RESLINE_SIZE
);
   logic              enable;
   logic [11:0]       counterX;
   logic [11:0]       counterY;
   logic              de_in;
   logic              hsync_in;
   logic              vsync_in;
   logic [23:0]       rgb_in;
   logic [3:0]        rom_addr;
   logic [LINE_W-1:0] rom_q;
   logic              de_out;
   logic              hsync_out;
   logic              vsync_out;
   logic [23:0]       rgb_out;

   modport master (
      output enable, counterX, counterY, de_in, hsync_in, vsync_in, rgb_in, rom_q,
      input  rom_addr, de_out, hsync_out, vsync_out, rgb_out
   );

   modport slave (
      input  enable, counterX, counterY, de_in, hsync_in, vsync_in, rgb_in, rom_q,
      output rom_addr, de_out, hsync_out, vsync_out, rgb_out
   );
endinterface

// File: rtl/resolution_overlay.sv
// Draws the resolution label bitmap (magnified SCALE x SCALE) into the pixel
// stream at a fixed position; all video signals are delayed by 2 cycles.
`ifndef RESLINE_SIZE
`define RESLINE_SIZE 16
`endif

module resolution_overlay #(
   parameter int          LINE_W     = `RESLINE_SIZE,
   parameter int          X_ORIGIN   = 16,
   parameter int          Y_ORIGIN   = 16,
   parameter int          SCALE_LOG2 = 1,
   parameter logic [23:0] FG_RGB     = 24'hFFFFFF,
   parameter logic [23:0] BG_RGB     = 24'h000000
) (
   input logic                clock,
   input logic                reset_n,
   resolution_overlay_if.slave bus
);

   localparam int               SCALE    = 1 << SCALE_LOG2;
   localparam int               BIT_W    = (LINE_W > 1) ? $clog2(LINE_W) : 1;
   localparam logic [12:0]      Y_LO     = 13'(Y_ORIGIN);
   localparam logic [12:0]      Y_HI     = 13'(Y_ORIGIN + 16 * SCALE);
   localparam logic [11:0]      X_START  = 12'(X_ORIGIN);
   localparam logic [11:0]      X_LATCH  = 12'(X_ORIGIN - 1);
   localparam logic [2:0]       SUB_LAST = 3'(SCALE - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(LINE_W - 1);

   logic [LINE_W-1:0] line_reg;
   logic              frame_en;
   logic              active;
   logic [2:0]        sub;
   logic [BIT_W-1:0]  bit_cnt;
   logic [3:0]        rom_addr_r;

   logic [12:0]       dy;
   logic              in_rows;
   logic              start;
   logic              cur_active;
   logic [2:0]        cur_sub;
   logic [BIT_W-1:0]  cur_bit;
   logic [23:0]       pix;

   logic [1:0]        de_pipe;
   logic [1:0]        hs_pipe;
   logic [1:0]        vs_pipe;
   logic [1:0][23:0]  rgb_pipe;

   // Walk state seen by the current pixel: a start on this very column
   // overrides the registered counters so column X_ORIGIN already shows bit 0.
   always_comb begin
      dy         = {1'b0, bus.counterY} - Y_LO;
      in_rows    = ({1'b0, bus.counterY} >= Y_LO) && ({1'b0, bus.counterY} < Y_HI);
      start      = (bus.counterX == X_START) && in_rows && frame_en;
      cur_active = start || (active && (bus.counterX != 12'd0));
      cur_sub    = start ? 3'd0 : sub;
      cur_bit    = start ? '0 : bit_cnt;
      pix        = bus.rgb_in;
      if (!bus.de_in)
         pix = 24'd0;
      else if (cur_active)
         pix = line_reg[BIT_LAST - cur_bit] ? FG_RGB : BG_RGB;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         line_reg   <= '0;
         frame_en   <= 1'b0;
         active     <= 1'b0;
         sub        <= 3'd0;
         bit_cnt    <= '0;
         rom_addr_r <= 4'd0;
      end else begin
         if (bus.counterX == 12'd0 && bus.counterY == 12'd0)
            frame_en <= bus.enable;
         if (bus.counterX == X_LATCH)
            line_reg <= bus.rom_q;
         rom_addr_r <= in_rows ? 4'(dy >> SCALE_LOG2) : 4'd0;
         active  <= cur_active;
         sub     <= cur_sub;
         bit_cnt <= cur_bit;
         if (cur_active) begin
            if (cur_sub == SUB_LAST) begin
               sub <= 3'd0;
               if (cur_bit == BIT_LAST)
                  active <= 1'b0;
               else
                  bit_cnt <= cur_bit + 1'b1;
            end else begin
               sub <= cur_sub + 3'd1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         de_pipe  <= '0;
         hs_pipe  <= '0;
         vs_pipe  <= '0;
         rgb_pipe <= '0;
      end else begin
         de_pipe  <= {de_pipe[0], bus.de_in};
         hs_pipe  <= {hs_pipe[0], bus.hsync_in};
         vs_pipe  <= {vs_pipe[0], bus.vsync_in};
         rgb_pipe <= {rgb_pipe[0], pix};
      end
   end

   assign bus.rom_addr  = rom_addr_r;
   assign bus.de_out    = de_pipe[1];
   assign bus.hsync_out = hs_pipe[1];
   assign bus.vsync_out = vs_pipe[1];
   assign bus.rgb_out   = rgb_pipe[1];

endmodule
